// File: rtl/di_i2_wb_buffer.sv
// Issue-2 writeback buffer: in-order FIFO drained through regfile port b2, with RAW visibility on a2/b2.
// Define DI_WB_FWD_EN to forward buffered data on reads; otherwise pending hits raise raw_stall_o.
module di_i2_wb_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid_i,
  output logic                     wb_ready_o,
  input  logic [ADDR_WIDTH-1:0]    wb_addr_i,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  input  logic                     port_busy_i,
  output logic [ADDR_WIDTH-1:0]    waddr_b2_o,
  output logic [DATA_WIDTH-1:0]    wdata_b2_o,
  output logic                     we_b2_o,
  input  logic [ADDR_WIDTH-1:0]    raddr_a2_i,
  input  logic [ADDR_WIDTH-1:0]    raddr_b2_i,
  input  logic [DATA_WIDTH-1:0]    rdata_a2_rf_i,
  input  logic [DATA_WIDTH-1:0]    rdata_b2_rf_i,
  output logic [DATA_WIDTH-1:0]    rdata_a2_o,
  output logic [DATA_WIDTH-1:0]    rdata_b2_o,
  output logic                     raw_stall_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q;
  logic                  drain, enq;
  logic                  hit_a, hit_b;
  logic [PTR_W-1:0]      idx;

  assign drain      = (count_q != '0) & ~port_busy_i;
  assign we_b2_o    = drain;
  assign wb_ready_o = (count_q < CNT_W'(DEPTH)) | drain;
  // x0 writes are acknowledged but never stored
  assign enq        = wb_valid_i & wb_ready_o & (wb_addr_i != '0);
  assign waddr_b2_o = addr_q[head_q];
  assign wdata_b2_o = data_q[head_q];
  assign count_o    = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        addr_q[tail_q] <= wb_addr_i;
        data_q[tail_q] <= wb_data_i;
        tail_q         <= tail_q + 1'b1;
      end
      if (drain) head_q <= head_q + 1'b1;
      count_q <= count_q + CNT_W'(enq) - CNT_W'(drain);
    end
  end

`ifdef DI_WB_FWD_EN
  logic [DATA_WIDTH-1:0] fwd_a, fwd_b;
`endif

  // Walk oldest to youngest so the youngest hit overwrites earlier ones.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    idx   = '0;
`ifdef DI_WB_FWD_EN
    fwd_a = rdata_a2_rf_i;
    fwd_b = rdata_b2_rf_i;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if ((raddr_a2_i != '0) && (addr_q[idx] == raddr_a2_i)) begin
          hit_a = 1'b1;
`ifdef DI_WB_FWD_EN
          fwd_a = data_q[idx];
`endif
        end
        if ((raddr_b2_i != '0) && (addr_q[idx] == raddr_b2_i)) begin
          hit_b = 1'b1;
`ifdef DI_WB_FWD_EN
          fwd_b = data_q[idx];
`endif
        end
      end
    end
  end

`ifdef DI_WB_FWD_EN
  assign rdata_a2_o  = fwd_a;
  assign rdata_b2_o  = fwd_b;
  assign raw_stall_o = 1'b0;
  logic unused_hits;
  assign unused_hits = hit_a ^ hit_b;
`else
  assign rdata_a2_o  = rdata_a2_rf_i;
  assign rdata_b2_o  = rdata_b2_rf_i;
  assign raw_stall_o = hit_a | hit_b;
`endif

endmodule

// File: tb/tb_di_i2_wb_buffer.sv
// Directed bench for di_i2_wb_buffer; expectations are hand-computed for DEPTH=4.
module tb_di_i2_wb_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid_i;
  logic        wb_ready_o;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        port_busy_i;
  logic [4:0]  waddr_b2_o;
  logic [31:0] wdata_b2_o;
  logic        we_b2_o;
  logic [4:0]  raddr_a2_i, raddr_b2_i;
  logic [31:0] rdata_a2_rf_i, rdata_b2_rf_i;
  logic [31:0] rdata_a2_o, rdata_b2_o;
  logic        raw_stall_o;
  logic [2:0]  count_o;

  int n_cmp = 0;
  int n_err = 0;

  di_i2_wb_buffer #(.DEPTH(4), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .port_busy_i(port_busy_i),
    .waddr_b2_o(waddr_b2_o), .wdata_b2_o(wdata_b2_o), .we_b2_o(we_b2_o),
    .raddr_a2_i(raddr_a2_i), .raddr_b2_i(raddr_b2_i),
    .rdata_a2_rf_i(rdata_a2_rf_i), .rdata_b2_rf_i(rdata_b2_rf_i),
    .rdata_a2_o(rdata_a2_o), .rdata_b2_o(rdata_b2_o),
    .raw_stall_o(raw_stall_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then let combinational outputs settle before checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wb_valid_i = 1'b1;
    wb_addr_i  = a;
    wb_data_i  = d;
    tick();
    wb_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wb_valid_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    port_busy_i = 1'b0; raddr_a2_i = '0; raddr_b2_i = '0;
    rdata_a2_rf_i = 32'h0000_1234; rdata_b2_rf_i = 32'h0000_5678;
    tick(); tick();
    rst = 1'b0;
    settle();
    check("rst_count", count_o, 0);
    check("rst_we", we_b2_o, 0);
    check("rst_ready", wb_ready_o, 1);
    check("rst_stall", raw_stall_o, 0);
    check("rst_waddr", waddr_b2_o, 0);
    check("rst_wdata", wdata_b2_o, 0);
    check("rst_rdata_a", rdata_a2_o, 32'h0000_1234);
    check("rst_rdata_b", rdata_b2_o, 32'h0000_5678);

    // single write, port free; entry being enqueued is not yet visible
    wb_valid_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hA5A5_0001; raddr_a2_i = 5'd5;
    settle();
    check("s_ready", wb_ready_o, 1);
    check("s_we_c0", we_b2_o, 0);
    check("s_stall_c0", raw_stall_o, 0);
    tick();
    wb_valid_i = 1'b0;
    settle();
    check("s_we_c1", we_b2_o, 1);
    check("s_waddr", waddr_b2_o, 5);
    check("s_wdata", wdata_b2_o, 32'hA5A5_0001);
    check("s_count_c1", count_o, 1);
`ifdef DI_WB_FWD_EN
    check("s_fwd_drain", rdata_a2_o, 32'hA5A5_0001);
`else
    check("s_stall_drain", raw_stall_o, 1);
`endif
    tick();
    check("s_count_c2", count_o, 0);
    check("s_we_c2", we_b2_o, 0);
    check("s_stall_c2", raw_stall_o, 0);
    raddr_a2_i = '0;

    // fill while busy, then release
    port_busy_i = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i));
    check("f_count", count_o, 4);
    check("f_ready", wb_ready_o, 0);
    check("f_we", we_b2_o, 0);
    port_busy_i = 1'b0;
    settle();
    check("f_ready_rel", wb_ready_o, 1);
    for (int i = 1; i <= 4; i++) begin
      check("f_we_drain", we_b2_o, 1);
      check("f_waddr", waddr_b2_o, 64'(i));
      check("f_wdata", wdata_b2_o, 64'(32'h100 + 32'(i)));
      check("f_count_drain", count_o, 64'(5 - i));
      tick();
    end
    check("f_empty", count_o, 0);
    check("f_we_end", we_b2_o, 0);

    // full buffer plus simultaneous enqueue/drain
    port_busy_i = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h200 + 32'(i));
    port_busy_i = 1'b0;
    wb_valid_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'h99;
    settle();
    check("fs_ready", wb_ready_o, 1);
    check("fs_waddr0", waddr_b2_o, 1);
    tick();
    wb_valid_i = 1'b0;
    check("fs_count", count_o, 4);
    for (int i = 2; i <= 4; i++) begin
      check("fs_waddr", waddr_b2_o, 64'(i));
      tick();
    end
    check("fs_x9_we", we_b2_o, 1);
    check("fs_x9_addr", waddr_b2_o, 9);
    check("fs_x9_data", wdata_b2_o, 32'h99);
    check("fs_x9_count", count_o, 1);
    tick();
    check("fs_empty", count_o, 0);

    // duplicate destination x7, youngest wins / stall until both drain
    port_busy_i = 1'b1;
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    raddr_a2_i = 5'd7; raddr_b2_i = 5'd3;
    settle();
`ifdef DI_WB_FWD_EN
    check("x7_fwd_a", rdata_a2_o, 32'h22);
    check("x7_stall", raw_stall_o, 0);
`else
    check("x7_stall", raw_stall_o, 1);
    check("x7_rdata_a", rdata_a2_o, 32'h0000_1234);
`endif
    check("x7_rdata_b", rdata_b2_o, 32'h0000_5678);
    raddr_a2_i = 5'd2; raddr_b2_i = 5'd7;
    settle();
`ifdef DI_WB_FWD_EN
    check("x7_fwd_b", rdata_b2_o, 32'h22);
`else
    check("x7_stall_b", raw_stall_o, 1);
`endif
    raddr_a2_i = 5'd7; raddr_b2_i = 5'd0;
    port_busy_i = 1'b0;
    settle();
    check("x7_wd1", wdata_b2_o, 32'h11);
`ifndef DI_WB_FWD_EN
    check("x7_stall_d1", raw_stall_o, 1);
`endif
    tick();
    check("x7_wd2", wdata_b2_o, 32'h22);
`ifndef DI_WB_FWD_EN
    check("x7_stall_d2", raw_stall_o, 1);
`endif
    tick();
    check("x7_stall_done", raw_stall_o, 0);
    check("x7_rf_after", rdata_a2_o, 32'h0000_1234);
    check("x7_count", count_o, 0);
    raddr_a2_i = '0;

    // x0 handling
    wb_valid_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hDEAD;
    settle();
    check("x0_ready", wb_ready_o, 1);
    tick();
    wb_valid_i = 1'b0;
    check("x0_count", count_o, 0);
    check("x0_we", we_b2_o, 0);
    port_busy_i = 1'b1;
    push(5'd3, 32'h33);
    raddr_b2_i = 5'd0;
    settle();
    check("x0_rd_stall", raw_stall_o, 0);
    check("x0_rd_data", rdata_b2_o, 32'h0000_5678);

    // reset mid-drain: x3 plus two more pending
    push(5'd11, 32'hB);
    push(5'd12, 32'hC);
    check("r_count_pre", count_o, 3);
    port_busy_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("r_count", count_o, 0);
    check("r_we", we_b2_o, 0);
    check("r_ready", wb_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r_no_write", we_b2_o, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
